// File: rtl/vga_display_pkg.sv
// Shared VGA 640x480@60 timing constants and the display FSM state encoding.
package vga_display_pkg;

    localparam int unsigned H_VIS   = 640;
    localparam int unsigned H_FP    = 16;
    localparam int unsigned H_SYNC  = 96;
    localparam int unsigned H_BP    = 48;
    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_VIS   = 480;
    localparam int unsigned V_FP    = 10;
    localparam int unsigned V_SYNC  = 2;
    localparam int unsigned V_BP    = 33;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam int unsigned H_SYNC_START = H_VIS + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_VIS + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int unsigned H_CNT_W = 10;
    localparam int unsigned V_CNT_W = 10;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        ARM   = 2'd1,
        SHOW  = 2'd2
    } state_e;

endpackage

// File: rtl/vga_display_timing.sv
// Pixel-tick divider, h/v raster counters and raw (unregistered) active-low syncs.
module vga_timing
    import vga_display_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
)(
    input  logic               clk_p,
    input  logic               rst,
    output logic               tick,
    output logic [H_CNT_W-1:0] h_cnt,
    output logic [V_CNT_W-1:0] v_cnt,
    output logic               hsync_raw,
    output logic               vsync_raw
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0]   div_q, div_d;
    logic [H_CNT_W-1:0] h_q, h_d;
    logic [V_CNT_W-1:0] v_q, v_d;

    always_comb begin
        tick  = (div_q == DIV_W'(CLK_DIV - 1));
        div_d = tick ? '0 : div_q + 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        if (tick) begin
            if (h_q == H_CNT_W'(H_TOTAL - 1)) begin
                h_d = '0;
                v_d = (v_q == V_CNT_W'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_p) begin
        if (rst) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    always_comb begin
        h_cnt     = h_q;
        v_cnt     = v_q;
        hsync_raw = !((h_q >= H_CNT_W'(H_SYNC_START)) && (h_q < H_CNT_W'(H_SYNC_END)));
        vsync_raw = !((v_q >= V_CNT_W'(V_SYNC_START)) && (v_q < V_CNT_W'(V_SYNC_END)));
    end

endmodule

// File: rtl/vga_display.sv
// Frame-buffer VGA scan-out: address generation, 2-stage output pipeline and
// BLANK/ARM/SHOW gating so a frame is only shown once upstream has finished it.
module vga_display
    import vga_display_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 12,
    parameter int unsigned ADDR_WIDTH  = 19,
    parameter int unsigned DATA_LENGTH = 120000,
    parameter int unsigned IMG_W       = 400,
    parameter int unsigned IMG_H       = 300,
    parameter int unsigned H_OFF       = 120,
    parameter int unsigned V_OFF       = 90,
    parameter int unsigned CLK_DIV     = 4
)(
    input  logic                  clk_p,
    input  logic                  rst,
    input  logic                  all_ready,
    output logic [ADDR_WIDTH-1:0] r_addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [3:0]            vga_r,
    output logic [3:0]            vga_g,
    output logic [3:0]            vga_b,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  frame_done
);

    logic               tick, hsync_raw, vsync_raw;
    logic [H_CNT_W-1:0] h_cnt;
    logic [V_CNT_W-1:0] v_cnt;

    vga_timing #(.CLK_DIV(CLK_DIV)) u_timing (
        .clk_p     (clk_p),
        .rst       (rst),
        .tick      (tick),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw)
    );

    state_e                state_q, state_d;
    logic                  show;
    logic                  in_win, last_px, frame_end;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data1_q, data1_d, rgb_q, rgb_d;
    logic                  win1_q, win1_d, last1_q, last1_d;
    logic                  hs1_q, hs1_d, vs1_q, vs1_d;
    logic                  hs2_q, hs2_d, vs2_q, vs2_d;
    logic                  fd_q, fd_d;

    always_comb begin
        in_win    = (h_cnt >= H_CNT_W'(H_OFF)) && (h_cnt < H_CNT_W'(H_OFF + IMG_W)) &&
                    (v_cnt >= V_CNT_W'(V_OFF)) && (v_cnt < V_CNT_W'(V_OFF + IMG_H));
        last_px   = (h_cnt == H_CNT_W'(H_OFF + IMG_W - 1)) && (v_cnt == V_CNT_W'(V_OFF + IMG_H - 1));
        frame_end = tick && (h_cnt == H_CNT_W'(H_TOTAL - 1)) && (v_cnt == V_CNT_W'(V_TOTAL - 1));
    end

    // addr_q moves with the counters, so it always names the pixel at the current (h,v)
    always_comb begin
        addr_d  = addr_q;
        data1_d = data1_q;
        win1_d  = win1_q;
        last1_d = last1_q;
        hs1_d   = hs1_q;
        vs1_d   = vs1_q;
        rgb_d   = rgb_q;
        hs2_d   = hs2_q;
        vs2_d   = vs2_q;
        fd_d    = tick && last1_q && show;
        if (tick) begin
            if (frame_end) begin
                addr_d = '0;
            end else if (in_win && (addr_q != ADDR_WIDTH'(DATA_LENGTH - 1))) begin
                addr_d = addr_q + 1'b1;
            end
            data1_d = data_in;
            win1_d  = in_win;
            last1_d = last_px;
            hs1_d   = hsync_raw;
            vs1_d   = vsync_raw;
            rgb_d   = (win1_q && show) ? data1_q : '0;
            hs2_d   = hs1_q;
            vs2_d   = vs1_q;
        end
    end

    always_ff @(posedge clk_p) begin
        if (rst) begin
            addr_q  <= '0;
            data1_q <= '0;
            win1_q  <= 1'b0;
            last1_q <= 1'b0;
            hs1_q   <= 1'b1;
            vs1_q   <= 1'b1;
            rgb_q   <= '0;
            hs2_q   <= 1'b1;
            vs2_q   <= 1'b1;
            fd_q    <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            data1_q <= data1_d;
            win1_q  <= win1_d;
            last1_q <= last1_d;
            hs1_q   <= hs1_d;
            vs1_q   <= vs1_d;
            rgb_q   <= rgb_d;
            hs2_q   <= hs2_d;
            vs2_q   <= vs2_d;
            fd_q    <= fd_d;
        end
    end

    always_ff @(posedge clk_p) begin
        if (rst) begin
            state_q <= BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    // Arming waits for the frame boundary so a frame is never shown half-way in
    always_comb begin
        state_d = state_q;
        case (state_q)
            BLANK:   if (all_ready) state_d = ARM;
            ARM:     if (frame_end) state_d = SHOW;
            SHOW:    state_d = SHOW;
            default: state_d = BLANK;
        endcase
        if (!all_ready) begin
            state_d = BLANK;
        end
    end

    always_comb begin
        show = (state_q == SHOW);
    end

    always_comb begin
        r_addr     = addr_q;
        vga_r      = rgb_q[11:8];
        vga_g      = rgb_q[7:4];
        vga_b      = rgb_q[3:0];
        hsync      = hs2_q;
        vsync      = vs2_q;
        frame_done = fd_q;
    end

endmodule
